slot_result_ctrl: RTL and testbench
===================================

SLOT_RESULT_CTRL -- requirements
Module: slot_result_ctrl

Interface
REQ-001 Parameter REFRESH_DIV, default 50000, clk cycles per display digit slot.
REQ-002 Parameter INIT_CREDITS, default 10, credit count loaded at reset (8-bit).
REQ-003 Parameter BLINK_DIV, default 12500000, clk cycles per blink half-period (used only when SLOT_BLINK_EN is defined).
REQ-004 The clock shall be clk; reset shall be reset, asynchronous, active-high.
REQ-005 clk  in  1  system clock, all state on rising edge.
REQ-006 reset  in  1  asynchronous active-high reset.
REQ-007 spin  in  1  level; 1 = player requests spin (reels stopping), 0 = released.
REQ-008 reel_stop  in  4  level per reel; bit i high once reel i+1 has stopped.
REQ-009 reel_num1..reel_num4  in  4 each  current value of reels 1..4.
REQ-010 seg  out  7  active-low segments {g,f,e,d,c,b,a}.
REQ-011 an  out  4  active-low digit anodes; an[3] = reel 1 (leftmost), an[0] = reel 4.
REQ-012 score  out  4  payout of last completed spin.
REQ-013 score_valid  out  1  high while score holds a completed spin's result.
REQ-014 credits  out  8  current credit balance.
REQ-015 busy  out  1  high in SPIN and SCORE states.

Function
REQ-016 FSM states IDLE, SPIN, SCORE, SHOW; reset state IDLE.
REQ-017 IDLE: on spin rising edge (spin=1, registered previous spin=0) with credits>0 -> SPIN; credits decremented by 1, all four digit-valid flags cleared, score_valid cleared, same edge.
REQ-018 IDLE: spin rising edge with credits=0 is ignored; state, score, score_valid unchanged.
REQ-019 SPIN: on rising edge of reel_stop[i] (registered previous bit 0), latch the matching reel_num into digit i and set its valid flag at that edge.
REQ-020 Multiple reel_stop bits rising in the same cycle shall all latch in that cycle.
REQ-021 SPIN: when all four valid flags are set -> SCORE on the next edge.
REQ-022 SPIN: spin falling before all four latched -> IDLE; no refund, latched digits retained, score_valid stays 0.
REQ-023 SCORE (one cycle): on exit edge, score computed, score_valid=1, credits += score saturating at 255, -> SHOW.
REQ-024 score_valid shall rise exactly two edges after the edge that latched the last reel.
REQ-025 Score rule by digit multiplicity: four equal = 8; three equal = 4; two distinct pairs = 2; exactly one pair = 1; all distinct = 0.
REQ-026 SHOW: hold score and digits; spin=0 -> IDLE; score_valid remains 1 until next accepted spin.
REQ-027 Display scan: divider counts 0..REFRESH_DIV-1 then wraps and advances 2-bit digit index 3->2->1->0->3; exactly one an bit low at all times.
REQ-028 Digit with valid flag set shall decode hex 0-F onto seg; digit without valid flag shall show blank (seg=7'h7F).
REQ-029 busy = 1 only in SPIN and SCORE.

Reset
REQ-030 During reset: state IDLE, credits=INIT_CREDITS, score=0, score_valid=0, busy=0, digits and valid flags 0, divider 0, scan index at an[3], an=4'b0111, seg=7'h7F.
REQ-031 Reset asserted mid-SPIN or mid-SCORE shall abandon the spin with no credit change beyond the reset value.

Configuration
REQ-032 Macro SLOT_BLINK_EN defined: in SHOW with score>=4, all anodes forced high (blank) during alternate BLINK_DIV half-periods; counter restarts on entry to SHOW, first half-period lit.
REQ-033 Macro SLOT_BLINK_EN undefined: no blink logic, display always lit per REQ-027/028.

Verification
REQ-034 Reset, spin rise, reel_stop 0001/0011/0111/1111 with nums 7,7,7,7 -> score=8, score_valid 2 edges after last latch, credits 10->9->17.
REQ-035 Nums 3,3,5,5 -> score=2; nums 1,2,3,1 -> score=1; nums 1,2,3,4 -> score=0, credits decrement only.
REQ-036 Credits=0 (INIT_CREDITS=0), spin pulse -> state IDLE, busy=0, credits 0.
REQ-037 Spin dropped after two reels latched -> IDLE, credits decremented, two digits shown, two blank, score_valid=0.
REQ-038 Credits=250, four-of-kind -> credits saturate at 255; all reel_stop bits rise same cycle -> all four latch that cycle.
REQ-039 REFRESH_DIV=4: an sequence 0111,1011,1101,1110 each 4 cycles, wraps; blank digits give seg=7'h7F.

Source files
------------

// File: rtl/slot_result_ctrl.sv
// ============================================================================
// slot_result_ctrl
// ----------------------------------------------------------------------------
// Slot-machine result controller. A spin press costs one credit, then each
// reel's value is captured as that reel reports stopped. Once all four are
// captured, the payout is scored and added to the credit balance, saturating
// at 255. The four captured reels are shown on a multiplexed, active-low,
// 4-digit 7-segment display.
//
// Ports
//   clk          in   system clock; all state changes on the rising edge
//   reset        in   asynchronous, active-high reset
//   spin         in   level; 1 = player holds spin, 0 = released
//   reel_stop    in   [3:0] bit i goes high once reel i+1 has stopped
//   reel_num1..4 in   [3:0] current value of reels 1..4
//   seg          out  [6:0] active-low segments {g,f,e,d,c,b,a}
//   an           out  [3:0] active-low anodes, an[3] = reel 1, an[0] = reel 4
//   score        out  [3:0] payout of the last completed spin
//   score_valid  out  score holds the result of a completed spin
//   credits      out  [7:0] current credit balance
//   busy         out  high in SPIN and SCORE
//
// Parameters
//   REFRESH_DIV   clk cycles per display digit slot
//   INIT_CREDITS  credit balance loaded at reset (8-bit)
//   BLINK_DIV     clk cycles per blink half-period (SLOT_BLINK_EN only)
//
// Build option
//   SLOT_BLINK_EN  when defined, a payout of 4 or more blinks the display in
//                  SHOW. The first half-period is lit.
// ============================================================================
module slot_result_ctrl #(
    parameter int unsigned REFRESH_DIV  = 50000,
    parameter int unsigned INIT_CREDITS = 10,
    parameter int unsigned BLINK_DIV    = 12500000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       spin,
    input  logic [3:0] reel_stop,
    input  logic [3:0] reel_num1,
    input  logic [3:0] reel_num2,
    input  logic [3:0] reel_num3,
    input  logic [3:0] reel_num4,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic [3:0] score,
    output logic       score_valid,
    output logic [7:0] credits,
    output logic       busy
);

    // Divider values of zero would make the counters meaningless.
    if (REFRESH_DIV < 1) begin : g_bad_refresh
        $error("REFRESH_DIV must be at least 1");
    end
    if (BLINK_DIV < 1) begin : g_bad_blink
        $error("BLINK_DIV must be at least 1");
    end

    localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SPIN  = 2'd1,
        SCORE = 2'd2,
        SHOW  = 2'd3
    } state_t;

    state_t           state_q;
    logic [7:0]       credits_q;
    logic [3:0]       score_q;
    logic             score_valid_q;
    logic [3:0][3:0]  dig_q;        // dig_q[i] holds reel i+1
    logic [3:0]       vld_q;        // digit i has been captured this spin
    logic             spin_q;       // previous spin level, for edge detect
    logic [3:0]       stop_q;       // previous reel_stop, for edge detect

    logic [DIV_W-1:0] div_q, div_d;
    logic [1:0]       idx_q, idx_d; // scan index; 3 drives an[3] (reel 1)

    logic [3:0][3:0]  nums;
    logic [3:0]       stop_rise;
    logic             spin_rise;
    logic [3:0]       score_nxt;
    logic [8:0]       credit_sum;

    assign nums      = {reel_num4, reel_num3, reel_num2, reel_num1};
    assign stop_rise = reel_stop & ~stop_q;
    assign spin_rise = spin & ~spin_q;

    // Six pairwise comparisons classify the multiplicity uniquely:
    // four equal = 6 matches, three equal = 3, two pairs = 2, one pair = 1.
    function automatic logic [3:0] score_of(input logic [3:0][3:0] d);
        logic [2:0] m;
        m = 3'(d[0] == d[1]) + 3'(d[0] == d[2]) + 3'(d[0] == d[3])
          + 3'(d[1] == d[2]) + 3'(d[1] == d[3]) + 3'(d[2] == d[3]);
        case (m)
            3'd6:    score_of = 4'd8;
            3'd3:    score_of = 4'd4;
            3'd2:    score_of = 4'd2;
            3'd1:    score_of = 4'd1;
            default: score_of = 4'd0;
        endcase
    endfunction

    assign score_nxt  = score_of(dig_q);
    assign credit_sum = {1'b0, credits_q} + {5'd0, score_nxt};

`ifdef SLOT_BLINK_EN
    localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_DIV - 1);
    logic [BLK_W-1:0] blk_cnt_q;
    logic             blk_off_q;    // 1 = current half-period is blanked
`endif

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            credits_q     <= 8'(INIT_CREDITS);
            score_q       <= 4'd0;
            score_valid_q <= 1'b0;
            dig_q         <= '0;
            vld_q         <= 4'd0;
            spin_q        <= 1'b0;
            stop_q        <= 4'd0;
`ifdef SLOT_BLINK_EN
            blk_cnt_q     <= '0;
            blk_off_q     <= 1'b0;
`endif
        end else begin
            spin_q <= spin;
            stop_q <= reel_stop;
            case (state_q)
                IDLE: begin
                    if (spin_rise && credits_q != 8'd0) begin
                        state_q       <= SPIN;
                        credits_q     <= credits_q - 8'd1;
                        vld_q         <= 4'd0;
                        score_valid_q <= 1'b0;
                    end
                end
                SPIN: begin
                    if (&vld_q) begin
                        state_q <= SCORE;
                    end else begin
                        // Reels stopping in the same cycle all latch together.
                        for (int i = 0; i < 4; i++) begin
                            if (stop_rise[i]) begin
                                dig_q[i] <= nums[i];
                                vld_q[i] <= 1'b1;
                            end
                        end
                        // Abandoned spin: no refund, partial digits stay shown.
                        if (!spin) state_q <= IDLE;
                    end
                end
                SCORE: begin
                    score_q       <= score_nxt;
                    score_valid_q <= 1'b1;
                    credits_q     <= credit_sum[8] ? 8'hFF : credit_sum[7:0];
                    state_q       <= SHOW;
`ifdef SLOT_BLINK_EN
                    blk_cnt_q     <= '0;
                    blk_off_q     <= 1'b0;
`endif
                end
                SHOW: begin
                    if (!spin) state_q <= IDLE;
`ifdef SLOT_BLINK_EN
                    if (blk_cnt_q == BLK_LAST) begin
                        blk_cnt_q <= '0;
                        blk_off_q <= ~blk_off_q;
                    end else begin
                        blk_cnt_q <= blk_cnt_q + 1'b1;
                    end
`endif
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign score       = score_q;
    assign score_valid = score_valid_q;
    assign credits     = credits_q;
    assign busy        = (state_q == SPIN) || (state_q == SCORE);

    // ------------------------------------------------------------------
    // Display scan: the index walks 3->2->1->0 so reel 1 comes first
    // ------------------------------------------------------------------
    always_comb begin
        div_d = div_q + 1'b1;
        idx_d = idx_q;
        if (div_q == DIV_LAST) begin
            div_d = '0;
            idx_d = idx_q - 2'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q <= '0;
            idx_q <= 2'd3;
        end else begin
            div_q <= div_d;
            idx_q <= idx_d;
        end
    end

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;
            4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
            4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;
            4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
            4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;
            4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
            4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;
            4'hE: hex7 = 7'h06;  default: hex7 = 7'h0E;
        endcase
    endfunction

    logic [1:0] dsel;
    assign dsel = 2'd3 - idx_q;

    always_comb begin
        seg = vld_q[dsel] ? hex7(dig_q[dsel]) : 7'h7F;
        an  = ~(4'b0001 << idx_q);
`ifdef SLOT_BLINK_EN
        if (state_q == SHOW && score_q >= 4'd4 && blk_off_q) an = 4'hF;
`endif
    end

endmodule

// File: tb/tb_slot_result_ctrl.sv
module tb_slot_result_ctrl;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic spin_m = 1'b0, spin_s = 1'b0, spin_z = 1'b0;
    logic [3:0] reel_stop = 4'd0;
    logic [3:0] n1 = 4'd0, n2 = 4'd0, n3 = 4'd0, n4 = 4'd0;

    logic [6:0] seg_m, seg_s, seg_z;
    logic [3:0] an_m, an_s, an_z;
    logic [3:0] score_m, score_s, score_z;
    logic       sv_m, sv_s, sv_z;
    logic [7:0] cr_m, cr_s, cr_z;
    logic       busy_m, busy_s, busy_z;

    always #5 clk = ~clk;

    // Main instance, saturation instance (250 credits), zero-credit instance.
    slot_result_ctrl #(.REFRESH_DIV(4), .INIT_CREDITS(10), .BLINK_DIV(8)) u_m (
        .clk(clk), .reset(reset), .spin(spin_m), .reel_stop(reel_stop),
        .reel_num1(n1), .reel_num2(n2), .reel_num3(n3), .reel_num4(n4),
        .seg(seg_m), .an(an_m), .score(score_m), .score_valid(sv_m),
        .credits(cr_m), .busy(busy_m));
    slot_result_ctrl #(.REFRESH_DIV(4), .INIT_CREDITS(250), .BLINK_DIV(8)) u_s (
        .clk(clk), .reset(reset), .spin(spin_s), .reel_stop(reel_stop),
        .reel_num1(n1), .reel_num2(n2), .reel_num3(n3), .reel_num4(n4),
        .seg(seg_s), .an(an_s), .score(score_s), .score_valid(sv_s),
        .credits(cr_s), .busy(busy_s));
    slot_result_ctrl #(.REFRESH_DIV(4), .INIT_CREDITS(0), .BLINK_DIV(8)) u_z (
        .clk(clk), .reset(reset), .spin(spin_z), .reel_stop(reel_stop),
        .reel_num1(n1), .reel_num2(n2), .reel_num3(n3), .reel_num4(n4),
        .seg(seg_z), .an(an_z), .score(score_z), .score_valid(sv_z),
        .credits(cr_z), .busy(busy_z));

    bit sel = 1'b0;   // 0 = main instance, 1 = saturation instance
    wire [3:0] c_score = sel ? score_s : score_m;
    wire       c_sv    = sel ? sv_s    : sv_m;
    wire [7:0] c_cr    = sel ? cr_s    : cr_m;
    wire       c_busy  = sel ? busy_s  : busy_m;

    int vec_cnt = 0;
    int miss_cnt = 0;

    task automatic check(input string nm, input int act, input int exp);
        vec_cnt++;
        if (act !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_spin(input logic v);
        if (sel) spin_s = v; else spin_m = v;
    endtask

    // Full spin: press, latch reels (staggered or all at once), score, release.
    task automatic run_spin(input logic [3:0] a, b, c, d, input bit burst,
                            input logic [3:0] esc, input logic [7:0] edec,
                            input logic [7:0] efin, input string tag);
        reel_stop = 4'd0;
        n1 = a; n2 = b; n3 = c; n4 = d;
        set_spin(1'b1);
        tick();
        check({tag, " busy after press"}, c_busy, 1);
        check({tag, " credits after press"}, c_cr, edec);
        check({tag, " score_valid cleared"}, c_sv, 0);
        if (burst) begin
            reel_stop = 4'hF;
            tick();
        end else begin
            for (int k = 0; k < 4; k++) begin
                reel_stop[k] = 1'b1;
                tick();
            end
        end
        check({tag, " score_valid 0 at last latch"}, c_sv, 0);
        tick();
        check({tag, " score_valid 0 one edge later"}, c_sv, 0);
        check({tag, " busy in SCORE"}, c_busy, 1);
        tick();
        check({tag, " score_valid two edges later"}, c_sv, 1);
        check({tag, " score"}, c_score, esc);
        check({tag, " credits after score"}, c_cr, efin);
        check({tag, " busy in SHOW"}, c_busy, 0);
        set_spin(1'b0);
        tick();
        check({tag, " score_valid held in IDLE"}, c_sv, 1);
    endtask

    typedef struct {
        logic [3:0] a, b, c, d;
        logic [3:0] sc;
        logic [7:0] cr_dec, cr_fin;
    } vec_t;
    vec_t tbl[5];

    initial begin
        tbl[0] = '{a:4'd7, b:4'd7, c:4'd7, d:4'd7, sc:4'd8, cr_dec:8'd9,  cr_fin:8'd17};
        tbl[1] = '{a:4'd3, b:4'd3, c:4'd5, d:4'd5, sc:4'd2, cr_dec:8'd16, cr_fin:8'd18};
        tbl[2] = '{a:4'd1, b:4'd2, c:4'd3, d:4'd1, sc:4'd1, cr_dec:8'd17, cr_fin:8'd18};
        tbl[3] = '{a:4'd1, b:4'd2, c:4'd3, d:4'd4, sc:4'd0, cr_dec:8'd17, cr_fin:8'd17};
        tbl[4] = '{a:4'd5, b:4'd5, c:4'd2, d:4'd5, sc:4'd4, cr_dec:8'd16, cr_fin:8'd20};

        // ---------------- reset state ----------------
        repeat (2) @(posedge clk);
        #1;
        check("reset credits", cr_m, 10);
        check("reset score", score_m, 0);
        check("reset score_valid", sv_m, 0);
        check("reset busy", busy_m, 0);
        check("reset an", an_m, 4'b0111);
        check("reset seg", seg_m, 7'h7F);
        check("reset credits sat inst", cr_s, 250);
        check("reset credits zero inst", cr_z, 0);

        // ---------------- scan sequence, REFRESH_DIV=4 ----------------
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k <= 16; k++) begin
            logic [1:0] ei;
            logic [3:0] ea;
            if (k > 0) tick();
            ei = 2'(3 - ((k / 4) % 4));
            ea = ~(4'b0001 << ei);
            check($sformatf("scan an k=%0d", k), an_m, ea);
            check($sformatf("scan blank seg k=%0d", k), seg_m, 7'h7F);
        end

        // ---------------- table of full spins ----------------
        sel = 1'b0;
        for (int i = 0; i < 5; i++) begin
            run_spin(tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].d, 1'b0,
                     tbl[i].sc, tbl[i].cr_dec, tbl[i].cr_fin, $sformatf("vec%0d", i));
            if (i == 0) begin
                int t = 0;
                while (an_m != 4'b0111 && t < 20) begin tick(); t++; end
                check("vec0 wait for reel1 slot", int'(t < 20), 1);
                check("vec0 reel1 shows 7", seg_m, 7'h78);
            end
        end

        // ---------------- saturation + simultaneous latch ----------------
        sel = 1'b1;
        run_spin(4'd2, 4'd2, 4'd2, 4'd2, 1'b1, 4'd8, 8'd249, 8'd255, "sat");
        sel = 1'b0;
        reel_stop = 4'd0;

        // ---------------- zero credits ----------------
        spin_z = 1'b1;
        tick();
        tick();
        check("zero busy", busy_z, 0);
        check("zero credits", cr_z, 0);
        check("zero score_valid", sv_z, 0);
        spin_z = 1'b0;
        tick();

        // ---------------- spin dropped after two reels ----------------
        reel_stop = 4'd0;
        n1 = 4'd9; n2 = 4'd6; n3 = 4'd1; n4 = 4'd2;
        spin_m = 1'b1;
        tick();
        check("drop credits after press", cr_m, 19);
        reel_stop = 4'b0001; tick();
        reel_stop = 4'b0011; tick();
        spin_m = 1'b0;
        tick();
        check("drop busy", busy_m, 0);
        check("drop credits", cr_m, 19);
        check("drop score_valid", sv_m, 0);
        for (int k = 0; k < 16; k++) begin
            logic [6:0] es;
            case (an_m)
                4'b0111: es = 7'h10;
                4'b1011: es = 7'h02;
                default: es = 7'h7F;
            endcase
            check($sformatf("drop seg an=%b", an_m), seg_m, es);
            tick();
        end

        // ---------------- reset mid-spin ----------------
        reel_stop = 4'd0;
        spin_m = 1'b1;
        tick();
        check("midreset credits before", cr_m, 18);
        reel_stop = 4'b0001;
        tick();
        check("midreset busy before", busy_m, 1);
        reset = 1'b1;
        #1;
        check("midreset credits", cr_m, 10);
        check("midreset busy", busy_m, 0);
        check("midreset score_valid", sv_m, 0);
        check("midreset an", an_m, 4'b0111);
        spin_m = 1'b0;
        reel_stop = 4'd0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
